// File: rtl/ahb_slave_port_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_port_mux_if
//  Brief    : Bus bundle between masters/arbiter/slave and the slave-side
//             port multiplexer. The slave modport is the mux's view; the
//             master modport is the view of the surrounding environment that
//             drives the per-master buses and models the slave.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_slave_port_mux_if #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
);
    // Arbiter side
    logic [MASTER_NUM-1:0]             hgrant;
    logic                              hsel_arb;
    logic                              hwait;

    // Per-master address/control and write data
    logic [MASTER_NUM-1:0][ADDR_W-1:0] m_haddr;
    logic [MASTER_NUM-1:0][1:0]        m_htrans;
    logic [MASTER_NUM-1:0]             m_hwrite;
    logic [MASTER_NUM-1:0][2:0]        m_hsize;
    logic [MASTER_NUM-1:0][2:0]        m_hburst;
    logic [MASTER_NUM-1:0][DATA_W-1:0] m_hwdata;

    // Per-master return path
    logic [MASTER_NUM-1:0]             m_hready;
    logic [MASTER_NUM-1:0]             m_hresp;
    logic [DATA_W-1:0]                 m_hrdata;

    // Slave side
    logic                              s_hreadyout;
    logic                              s_hresp;
    logic [DATA_W-1:0]                 s_hrdata;
    logic                              s_hsel;
    logic [ADDR_W-1:0]                 s_haddr;
    logic [1:0]                        s_htrans;
    logic                              s_hwrite;
    logic [2:0]                        s_hsize;
    logic [2:0]                        s_hburst;
    logic [DATA_W-1:0]                 s_hwdata;
    logic                              s_hready;

    // Status
    logic [MASTER_NUM-1:0]             data_owner;
    logic                              onehot_err;

    modport slave (
        input  hgrant, hsel_arb,
        input  m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
        input  s_hreadyout, s_hresp, s_hrdata,
        output s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
        output s_hwdata, s_hready,
        output m_hready, m_hresp, m_hrdata,
        output hwait, data_owner, onehot_err
    );

    modport master (
        output hgrant, hsel_arb,
        output m_haddr, m_htrans, m_hwrite, m_hsize, m_hburst, m_hwdata,
        output s_hreadyout, s_hresp, s_hrdata,
        input  s_hsel, s_haddr, s_htrans, s_hwrite, s_hsize, s_hburst,
        input  s_hwdata, s_hready,
        input  m_hready, m_hresp, m_hrdata,
        input  hwait, data_owner, onehot_err
    );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_port_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_slave_port_mux
//  Brief    : Slave-side AHB address/data-phase multiplexer. Routes the
//             granted master's address/control to the slave, tracks the
//             pipelined data-phase owner, steers write data to the slave and
//             ready/response back to the owner, and raises hwait for the
//             arbiter while the owner's data phase is stalled.
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_slave_port_mux #(
    parameter int MASTER_NUM = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  wire logic             hclk,
    input  wire logic             hreset_n,
    ahb_slave_port_mux_if.slave   bus
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [MASTER_NUM-1:0] addr_sel_q;
    logic [MASTER_NUM-1:0] addr_sel;
    logic [MASTER_NUM-1:0] data_owner_q;
    logic                  onehot_err_q;
    logic                  grant_any;
    logic                  grant_multi;
    logic                  sel;

    logic [ADDR_W-1:0]     haddr_mux;
    logic [1:0]            htrans_mux;
    logic                  hwrite_mux;
    logic [2:0]            hsize_mux;
    logic [2:0]            hburst_mux;
    logic [DATA_W-1:0]     hwdata_mux;

    // Grant decode; more than one bit set is a protocol violation upstream
    always_comb begin
        grant_any   = |bus.hgrant;
        grant_multi = ($countones(bus.hgrant) > 1);
    end

    // Live grant wins; otherwise the remembered grant keeps the address
    // phase pointed at the same master while the arbiter masks hgrant.
    // Held at zero while reset is asserted so outputs show reset values.
    always_comb begin
        addr_sel = '0;
        if (hreset_n) begin
            addr_sel = grant_any ? bus.hgrant : addr_sel_q;
        end
    end

    // Remember the last non-zero grant; drop it once the arbiter deselects
    // this slave and the bus is ready
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            addr_sel_q <= '0;
        end else if (grant_any) begin
            addr_sel_q <= bus.hgrant;
        end else if (!bus.hsel_arb && bus.s_hreadyout) begin
            addr_sel_q <= '0;
        end
    end

    // AND-OR address/control mux; an illegal multi-hot grant ORs the inputs
    always_comb begin
        haddr_mux  = '0;
        htrans_mux = '0;
        hwrite_mux = 1'b0;
        hsize_mux  = '0;
        hburst_mux = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            haddr_mux  = haddr_mux  | ({ADDR_W{addr_sel[i]}} & bus.m_haddr[i]);
            htrans_mux = htrans_mux | ({2{addr_sel[i]}}      & bus.m_htrans[i]);
            hwrite_mux = hwrite_mux | (addr_sel[i]           & bus.m_hwrite[i]);
            hsize_mux  = hsize_mux  | ({3{addr_sel[i]}}      & bus.m_hsize[i]);
            hburst_mux = hburst_mux | ({3{addr_sel[i]}}      & bus.m_hburst[i]);
        end
    end

    // Slave address phase; everything is squashed to IDLE/zero when unselected
    always_comb begin
        sel          = (|addr_sel) & bus.hsel_arb;
        bus.s_hsel   = sel;
        bus.s_htrans = sel ? htrans_mux : HTRANS_IDLE;
        bus.s_haddr  = sel ? haddr_mux  : '0;
        bus.s_hwrite = sel ? hwrite_mux : 1'b0;
        bus.s_hsize  = sel ? hsize_mux  : '0;
        bus.s_hburst = sel ? hburst_mux : '0;
    end

    // Data-phase owner: advances only on a ready cycle; only NONSEQ/SEQ
    // address phases create a data phase
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            data_owner_q <= '0;
        end else if (bus.s_hreadyout) begin
            if (sel && htrans_mux[1]) begin
                data_owner_q <= addr_sel;
            end else begin
                data_owner_q <= '0;
            end
        end
    end

    // Sticky flag for a multi-hot grant; only reset clears it
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            onehot_err_q <= 1'b0;
        end else if (grant_multi) begin
            onehot_err_q <= 1'b1;
        end
    end

    // Write data follows the data-phase owner, zero when there is none
    always_comb begin
        hwdata_mux = '0;
        for (int i = 0; i < MASTER_NUM; i++) begin
            hwdata_mux = hwdata_mux | ({DATA_W{data_owner_q[i]}} & bus.m_hwdata[i]);
        end
    end

    // Data-phase and status outputs
    always_comb begin
        bus.s_hwdata   = hwdata_mux;
        bus.s_hready   = bus.s_hreadyout;
        bus.m_hrdata   = bus.s_hrdata;
        bus.hwait      = ~bus.s_hreadyout & (|data_owner_q);
        bus.data_owner = data_owner_q;
        bus.onehot_err = onehot_err_q;
    end

    // Per-master return path: a master involved in either phase sees the
    // slave's ready; only the data-phase owner sees the slave's response.
    // On a handover the old owner gets its data-phase ready while the new
    // master gets its address-phase ready in the same cycle.
    for (genvar i = 0; i < MASTER_NUM; i++) begin : g_master
        assign bus.m_hready[i] = (data_owner_q[i] | addr_sel[i]) ? bus.s_hreadyout : 1'b1;
        assign bus.m_hresp[i]  = data_owner_q[i] ? bus.s_hresp : 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_port_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_slave_port_mux
//  Brief    : Self-checking bench for ahb_slave_port_mux. Address phases push
//             the expected data-phase owner and write data into a scoreboard
//             queue; the data-phase cycle pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_port_mux;

    localparam int MASTER_NUM = 2;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] wdata;
    } exp_t;

    logic hclk;
    logic hreset_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    exp_t e;

    ahb_slave_port_mux_if #(.MASTER_NUM(MASTER_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_slave_port_mux #(.MASTER_NUM(MASTER_NUM), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Global time limit
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance to just after the next rising edge
    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic set_idle();
        bus.hgrant      = '0;
        bus.hsel_arb    = 1'b0;
        bus.m_haddr     = '0;
        bus.m_htrans    = '0;
        bus.m_hwrite    = '0;
        bus.m_hsize     = '0;
        bus.m_hburst    = '0;
        bus.m_hwdata    = '0;
        bus.s_hreadyout = 1'b1;
        bus.s_hresp     = 1'b0;
        bus.s_hrdata    = '0;
    endtask

    task automatic test_reset();
        hreset_n        = 1'b0;
        bus.hgrant      = 2'b01;
        bus.hsel_arb    = 1'b1;
        bus.m_htrans[0] = 2'b10;
        bus.m_haddr[0]  = 32'h0000_1234;
        bus.m_hwrite[0] = 1'b1;
        bus.m_hwdata[0] = 32'h5555_AAAA;
        cyc();
        cyc();
        #2;
        n_cmp++; if (bus.s_htrans !== 2'b00) begin n_err++; $display("FAIL reset_htrans: got %b want 00", bus.s_htrans); end
        n_cmp++; if (bus.s_hsel !== 1'b0) begin n_err++; $display("FAIL reset_hsel: got %b want 0", bus.s_hsel); end
        n_cmp++; if (bus.s_haddr !== 32'h0) begin n_err++; $display("FAIL reset_haddr: got %h want 0", bus.s_haddr); end
        n_cmp++; if (bus.m_hready !== 2'b11) begin n_err++; $display("FAIL reset_m_hready: got %b want 11", bus.m_hready); end
        n_cmp++; if (bus.data_owner !== 2'b00) begin n_err++; $display("FAIL reset_owner: got %b want 00", bus.data_owner); end
        n_cmp++; if (bus.onehot_err !== 1'b0) begin n_err++; $display("FAIL reset_onehot_err: got %b want 0", bus.onehot_err); end
        n_cmp++; if (bus.hwait !== 1'b0) begin n_err++; $display("FAIL reset_hwait: got %b want 0", bus.hwait); end
        n_cmp++; if (bus.s_hwdata !== 32'h0) begin n_err++; $display("FAIL reset_hwdata: got %h want 0", bus.s_hwdata); end
        cyc();
        hreset_n = 1'b1;
        set_idle();
        cyc();
    endtask

    task automatic test_single_write();
        // Address phase
        cyc();
        bus.hgrant      = 2'b01;
        bus.hsel_arb    = 1'b1;
        bus.m_htrans[0] = 2'b10;
        bus.m_haddr[0]  = 32'h0000_1000;
        bus.m_hwrite[0] = 1'b1;
        bus.m_hsize[0]  = 3'd2;
        sb.push_back('{owner: 2'b01, wdata: 32'hDEAD_BEEF});
        #2;
        n_cmp++; if (bus.s_haddr !== 32'h0000_1000) begin n_err++; $display("FAIL sw_haddr: got %h want 00001000", bus.s_haddr); end
        n_cmp++; if (bus.s_hsel !== 1'b1) begin n_err++; $display("FAIL sw_hsel: got %b want 1", bus.s_hsel); end
        n_cmp++; if (bus.s_htrans !== 2'b10) begin n_err++; $display("FAIL sw_htrans: got %b want 10", bus.s_htrans); end
        n_cmp++; if (bus.s_hwrite !== 1'b1) begin n_err++; $display("FAIL sw_hwrite: got %b want 1", bus.s_hwrite); end
        n_cmp++; if (bus.s_hsize !== 3'd2) begin n_err++; $display("FAIL sw_hsize: got %0d want 2", bus.s_hsize); end
        n_cmp++; if (bus.data_owner !== 2'b00) begin n_err++; $display("FAIL sw_owner_addr: got %b want 00", bus.data_owner); end
        // Data phase
        cyc();
        set_idle();
        bus.m_hwdata[0] = 32'hDEAD_BEEF;
        #2;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL sw_sb: got empty scoreboard want one entry");
        end else begin
            e = sb.pop_front();
            if (bus.data_owner !== e.owner || bus.s_hwdata !== e.wdata) begin
                n_err++;
                $display("FAIL sw_data: got owner %b wdata %h want owner %b wdata %h", bus.data_owner, bus.s_hwdata, e.owner, e.wdata);
            end
        end
        n_cmp++; if (bus.s_hsel !== 1'b0) begin n_err++; $display("FAIL sw_hsel_data: got %b want 0", bus.s_hsel); end
        cyc();
        #2;
        n_cmp++; if (bus.data_owner !== 2'b00) begin n_err++; $display("FAIL sw_owner_clr: got %b want 00", bus.data_owner); end
        n_cmp++; if (bus.s_hwdata !== 32'h0) begin n_err++; $display("FAIL sw_hwdata_clr: got %h want 0", bus.s_hwdata); end
    endtask

    task automatic test_wait_states();
        cyc();
        bus.hgrant      = 2'b01;
        bus.hsel_arb    = 1'b1;
        bus.m_htrans[0] = 2'b10;
        bus.m_haddr[0]  = 32'h0000_2000;
        bus.m_hwrite[0] = 1'b1;
        sb.push_back('{owner: 2'b01, wdata: 32'hCAFE_0001});
        // Two wait cycles: arbiter masks the grant, M0 holds its next address
        for (int w = 0; w < 2; w++) begin
            cyc();
            bus.hgrant      = 2'b00;
            bus.m_haddr[0]  = 32'h0000_2004;
            bus.m_hwdata[0] = 32'hCAFE_0001;
            bus.s_hreadyout = 1'b0;
            #2;
            n_cmp++; if (bus.hwait !== 1'b1) begin n_err++; $display("FAIL ws_hwait[%0d]: got %b want 1", w, bus.hwait); end
            n_cmp++; if (bus.m_hready !== 2'b10) begin n_err++; $display("FAIL ws_m_hready[%0d]: got %b want 10", w, bus.m_hready); end
            n_cmp++; if (bus.s_haddr !== 32'h0000_2004) begin n_err++; $display("FAIL ws_haddr[%0d]: got %h want 00002004", w, bus.s_haddr); end
            n_cmp++; if (bus.s_hready !== 1'b0) begin n_err++; $display("FAIL ws_s_hready[%0d]: got %b want 0", w, bus.s_hready); end
            if (w == 0) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++; $display("FAIL ws_sb: got empty scoreboard want one entry");
                end else begin
                    e = sb.pop_front();
                    if (bus.data_owner !== e.owner || bus.s_hwdata !== e.wdata) begin
                        n_err++;
                        $display("FAIL ws_data: got owner %b wdata %h want owner %b wdata %h", bus.data_owner, bus.s_hwdata, e.owner, e.wdata);
                    end
                end
            end else begin
                n_cmp++; if (bus.data_owner !== 2'b01) begin n_err++; $display("FAIL ws_owner_hold: got %b want 01", bus.data_owner); end
            end
        end
        // Third cycle completes the data phase and accepts the next address
        cyc();
        bus.s_hreadyout = 1'b1;
        sb.push_back('{owner: 2'b01, wdata: 32'hCAFE_0002});
        #2;
        n_cmp++; if (bus.hwait !== 1'b0) begin n_err++; $display("FAIL ws_hwait_done: got %b want 0", bus.hwait); end
        n_cmp++; if (bus.m_hready !== 2'b11) begin n_err++; $display("FAIL ws_m_hready_done: got %b want 11", bus.m_hready); end
        cyc();
        set_idle();
        bus.m_hwdata[0] = 32'hCAFE_0002;
        #2;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL ws_sb2: got empty scoreboard want one entry");
        end else begin
            e = sb.pop_front();
            if (bus.data_owner !== e.owner || bus.s_hwdata !== e.wdata) begin
                n_err++;
                $display("FAIL ws_data2: got owner %b wdata %h want owner %b wdata %h", bus.data_owner, bus.s_hwdata, e.owner, e.wdata);
            end
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        cyc();
        bus.hgrant      = 2'b01;
        bus.hsel_arb    = 1'b1;
        bus.m_htrans[0] = 2'b10;
        bus.m_haddr[0]  = 32'h0000_3000;
        bus.m_hwrite[0] = 1'b1;
        sb.push_back('{owner: 2'b01, wdata: 32'h1111_0000});
        // M0 data phase overlaps M1 address phase
        cyc();
        bus.hgrant      = 2'b10;
        bus.m_htrans[0] = 2'b00;
        bus.m_htrans[1] = 2'b10;
        bus.m_haddr[1]  = 32'h0000_4000;
        bus.m_hwrite[1] = 1'b1;
        bus.m_hwdata[0] = 32'h1111_0000;
        bus.m_hwdata[1] = 32'h2222_0000;
        sb.push_back('{owner: 2'b10, wdata: 32'h2222_0001});
        #2;
        n_cmp++; if (bus.s_haddr !== 32'h0000_4000) begin n_err++; $display("FAIL b2b_haddr: got %h want 00004000", bus.s_haddr); end
        n_cmp++; if (bus.m_hready !== 2'b11) begin n_err++; $display("FAIL b2b_m_hready: got %b want 11", bus.m_hready); end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL b2b_sb: got empty scoreboard want entries");
        end else begin
            e = sb.pop_front();
            if (bus.data_owner !== e.owner || bus.s_hwdata !== e.wdata) begin
                n_err++;
                $display("FAIL b2b_data_m0: got owner %b wdata %h want owner %b wdata %h", bus.data_owner, bus.s_hwdata, e.owner, e.wdata);
            end
        end
        // M1 data phase immediately follows
        cyc();
        set_idle();
        bus.m_hwdata[0] = 32'h0BAD_0BAD;
        bus.m_hwdata[1] = 32'h2222_0001;
        #2;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL b2b_sb2: got empty scoreboard want one entry");
        end else begin
            e = sb.pop_front();
            if (bus.data_owner !== e.owner || bus.s_hwdata !== e.wdata) begin
                n_err++;
                $display("FAIL b2b_data_m1: got owner %b wdata %h want owner %b wdata %h", bus.data_owner, bus.s_hwdata, e.owner, e.wdata);
            end
        end
        cyc();
    endtask

    task automatic test_error();
        cyc();
        bus.hgrant      = 2'b10;
        bus.hsel_arb    = 1'b1;
        bus.m_htrans[1] = 2'b10;
        bus.m_haddr[1]  = 32'h0000_5000;
        bus.m_hwrite[1] = 1'b0;
        // First ERROR cycle
        cyc();
        set_idle();
        bus.s_hreadyout = 1'b0;
        bus.s_hresp     = 1'b1;
        #2;
        n_cmp++; if (bus.m_hresp !== 2'b10) begin n_err++; $display("FAIL err1_m_hresp: got %b want 10", bus.m_hresp); end
        n_cmp++; if (bus.m_hready !== 2'b01) begin n_err++; $display("FAIL err1_m_hready: got %b want 01", bus.m_hready); end
        n_cmp++; if (bus.hwait !== 1'b1) begin n_err++; $display("FAIL err1_hwait: got %b want 1", bus.hwait); end
        // Second ERROR cycle
        cyc();
        bus.s_hreadyout = 1'b1;
        bus.s_hrdata    = 32'h5A5A_5A5A;
        #2;
        n_cmp++; if (bus.data_owner !== 2'b10) begin n_err++; $display("FAIL err2_owner: got %b want 10", bus.data_owner); end
        n_cmp++; if (bus.m_hresp !== 2'b10) begin n_err++; $display("FAIL err2_m_hresp: got %b want 10", bus.m_hresp); end
        n_cmp++; if (bus.m_hready !== 2'b11) begin n_err++; $display("FAIL err2_m_hready: got %b want 11", bus.m_hready); end
        n_cmp++; if (bus.m_hrdata !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL err2_hrdata: got %h want 5a5a5a5a", bus.m_hrdata); end
        cyc();
        set_idle();
        #2;
        n_cmp++; if (bus.m_hresp !== 2'b00) begin n_err++; $display("FAIL err_done_m_hresp: got %b want 00", bus.m_hresp); end
        n_cmp++; if (bus.data_owner !== 2'b00) begin n_err++; $display("FAIL err_done_owner: got %b want 00", bus.data_owner); end
    endtask

    task automatic test_onehot_err();
        cyc();
        bus.hgrant     = 2'b11;
        bus.hsel_arb   = 1'b1;
        bus.m_haddr[0] = 32'h0000_00F0;
        bus.m_haddr[1] = 32'h0000_0F00;
        #2;
        n_cmp++; if (bus.onehot_err !== 1'b0) begin n_err++; $display("FAIL oh_early: got %b want 0", bus.onehot_err); end
        n_cmp++; if (bus.s_haddr !== 32'h0000_0FF0) begin n_err++; $display("FAIL oh_or_mux: got %h want 00000ff0", bus.s_haddr); end
        cyc();
        set_idle();
        for (int k = 0; k < 4; k++) begin
            #2;
            n_cmp++; if (bus.onehot_err !== 1'b1) begin n_err++; $display("FAIL oh_sticky[%0d]: got %b want 1", k, bus.onehot_err); end
            cyc();
        end
        hreset_n = 1'b0;
        #1;
        n_cmp++; if (bus.onehot_err !== 1'b0) begin n_err++; $display("FAIL oh_reset_clr: got %b want 0", bus.onehot_err); end
        cyc();
        hreset_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        cyc();
        bus.hgrant      = 2'b10;
        bus.hsel_arb    = 1'b1;
        bus.m_htrans[1] = 2'b10;
        bus.m_haddr[1]  = 32'h0000_6000;
        bus.m_hwrite[1] = 1'b1;
        sb.push_back('{owner: 2'b10, wdata: 32'h6666_0000});
        cyc();
        set_idle();
        bus.s_hreadyout = 1'b0;
        bus.m_hwdata[1] = 32'h6666_0000;
        #2;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL rm_sb: got empty scoreboard want one entry");
        end else begin
            e = sb.pop_front();
            if (bus.data_owner !== e.owner || bus.s_hwdata !== e.wdata) begin
                n_err++;
                $display("FAIL rm_data: got owner %b wdata %h want owner %b wdata %h", bus.data_owner, bus.s_hwdata, e.owner, e.wdata);
            end
        end
        // Asynchronous reset between clock edges
        hreset_n = 1'b0;
        #1;
        n_cmp++; if (bus.data_owner !== 2'b00) begin n_err++; $display("FAIL rm_owner: got %b want 00", bus.data_owner); end
        n_cmp++; if (bus.hwait !== 1'b0) begin n_err++; $display("FAIL rm_hwait: got %b want 0", bus.hwait); end
        n_cmp++; if (bus.m_hready !== 2'b11) begin n_err++; $display("FAIL rm_m_hready: got %b want 11", bus.m_hready); end
        n_cmp++; if (bus.s_hwdata !== 32'h0) begin n_err++; $display("FAIL rm_hwdata: got %h want 0", bus.s_hwdata); end
        cyc();
        hreset_n = 1'b1;
        set_idle();
        cyc();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        hreset_n = 1'b0;
        set_idle();
        test_reset();
        test_single_write();
        test_wait_states();
        test_back_to_back();
        test_error();
        test_onehot_err();
        test_reset_mid();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d entries left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
